// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order FIFO between MEM stage and data memory.
// Ports: st_* push side, ld_* load probe/stall, mem_* shared memory port.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_strobe,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_strobe,
  output logic        ld_stall,
  output logic        empty,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_strobe,
  output logic        mem_wen
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [31:0]      addr_q   [DEPTH];
  logic [31:0]      addr_d   [DEPTH];
  logic [31:0]      data_q   [DEPTH];
  logic [31:0]      data_d   [DEPTH];
  logic [1:0]       strobe_q [DEPTH];
  logic [1:0]       strobe_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic hit;
  logic ld_go;
  logic push;
  logic pop;

  assign st_ready = (count_q < FULL);
  assign empty    = (count_q == '0);

  // Only already-stored entries are compared; a same-cycle push is not.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] &&
          addr_q[i][ADDR_W-1:0] == ld_addr[ADDR_W-1:0])
        hit = 1'b1;
    end
  end

  assign ld_stall = ld_valid && hit;
  assign ld_go    = ld_valid && !ld_stall;
  // A stalled load does not own the port, so draining always progresses.
  assign pop      = !ld_go && !empty;
  assign push     = st_valid && st_ready;

  always_comb begin
    mem_addr   = ld_addr;
    mem_strobe = ld_strobe;
    mem_wdata  = 32'h0;
    mem_wen    = 1'b0;
    if (pop) begin
      mem_addr   = addr_q[head_q];
      mem_strobe = strobe_q[head_q];
      mem_wdata  = data_q[head_q];
      mem_wen    = 1'b1;
    end
  end

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    strobe_d = strobe_q;
    valid_d  = valid_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (push) begin
      addr_d[tail_q]   = st_addr;
      data_d[tail_q]   = st_data;
      strobe_d[tail_q] = st_strobe;
      valid_d[tail_q]  = 1'b1;
      tail_d           = tail_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    addr_q   <= addr_d;
    data_q   <= data_d;
    strobe_q <= strobe_d;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the MEM pipeline stage and the word-addressed data memory. Stores from the MEM stage are accepted into a small in-order FIFO and retired to memory over the shared memory port on cycles when no load needs it. Loads always have port priority, except a load whose word address matches a pending store: it is stalled until that store has drained, which preserves program order. Retire order equals accept order; entries are never merged or reordered.

## Interface
- DEPTH, 4, number of buffered stores (power of two, ≥2)
- ADDR_W, 9, word-index bits compared for load/store overlap (memory indexes by addr[ADDR_W-1:0])

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  MEM stage presents a store this cycle
- st_addr  in  32  store address
- st_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- st_strobe  in  2  1 = byte, 2 = half, 0/3 = word (memory's encoding)
- st_ready  out  1  buffer can accept a store; equals count < DEPTH
- ld_valid  in  1  MEM stage presents a load this cycle
- ld_addr  in  32  load address
- ld_strobe  in  2  load width, same encoding
- ld_stall  out  1  load overlaps a pending store; pipeline must hold the load
- empty  out  1  no pending stores (used for fence / drain-before-halt)
- mem_addr  out  32  memory port address
- mem_wdata  out  32  memory port write data
- mem_strobe  out  2  memory port width
- mem_wen  out  1  memory port write enable

## Operation
- Storage: DEPTH entries of {addr, data, strobe, valid}; head/tail pointers of log2(DEPTH) bits wrap modulo DEPTH; count of log2(DEPTH)+1 bits.
- Push: st_valid && st_ready writes the entry at tail, tail+1, count+1. st_valid while !st_ready is ignored; the MEM stage stalls on !st_ready and the buffer must not corrupt state.
- Overlap: ld_stall = ld_valid && any valid entry has addr[ADDR_W-1:0] == ld_addr[ADDR_W-1:0]. Only entries already stored are compared; a store accepted in the same cycle is not compared.
- Port arbitration, combinational:
  - ld_valid && !ld_stall: mem_addr = ld_addr, mem_strobe = ld_strobe, mem_wdata = 0, mem_wen = 0.
  - else if !empty: drive the head entry's fields, mem_wen = 1 (drain).
  - else: mem_addr = ld_addr, mem_strobe = ld_strobe, mem_wdata = 0, mem_wen = 0.
- Pop: a drain cycle clears the head entry's valid bit, advances head by 1 and decrements count at the rising edge. A stalled load therefore never blocks draining, which guarantees forward progress.
- Simultaneous push and pop: both take effect and count is unchanged. Push is decided on the pre-edge st_ready, so when count == DEPTH no push occurs even if a pop happens in the same cycle.
- empty = (count == 0).

## Timing
- Reset (rst high at a rising edge): head = tail = count = 0 and all valid bits = 0. Resulting outputs: st_ready = 1, empty = 1, mem_wen = 0, ld_stall = 0. Reset overrides any push or pop in the same cycle; pending stores are discarded.
- Accept latency: a store pushed at edge N can drain in cycle N+1 at the earliest, with mem_wen high during that cycle. Memory commits the write on that cycle's falling edge.
- Occupancy: a single store with no load traffic occupies the buffer for exactly 1 cycle after acceptance.
- Stall release: ld_stall falls in the cycle after the last matching entry pops. The held load then reads the updated memory contents.
- All outputs except the pointer-derived flags are combinational from inputs plus entry state. No output depends on clk directly.

## Test plan
- Reset mid-operation: push 3 stores, assert rst for 1 cycle -> next cycle count = 0, empty = 1, st_ready = 1, mem_wen = 0; the 3 stores are never written.
- Single store, idle port: push word 0xDEADBEEF to addr 0x10 -> next cycle mem_wen = 1, mem_addr = 0x10, mem_wdata = 0xDEADBEEF, mem_strobe = 0; empty = 1 one cycle later.
- Fill and back-pressure: hold ld_valid with a non-matching addr while pushing 5 stores (DEPTH = 4) -> st_ready = 0 after the 4th push, the 5th is dropped, mem_wen = 0 throughout. Drop ld_valid -> 4 drains in push order on 4 consecutive cycles.
- Load-after-store hazard: push byte 0x7F to addr 0x20, load half from addr 0x20 the next cycle -> ld_stall = 1 while the byte drains (mem_wen = 1, mem_strobe = 1); the following cycle ld_stall = 0 and mem_addr = 0x20 with mem_wen = 0.
- Alias on word index: pending store at 0x204 and a load at 0x004 -> ld_stall = 1 (ADDR_W = 9 compares bits [8:0] only, so both map to index 0x004).
- Wrap and concurrency: drive a continuous stream with one push and one pop per cycle for 10 cycles -> count stays constant, pointers wrap past DEPTH-1 to 0, and memory writes match push order and data exactly.
